// File: rtl/spi_mem_responder.sv
// SPI mode-0 slave emulating a small word-addressed serial memory.
// Frame: 8-bit command (0x03 read, 0x02 write), 24-bit address, 32-bit data, MSB first.
// SPI pins are oversampled by CLK through 2-flop synchronisers.
// Optional burst mode: define SPI_RESP_AUTOINC_EN to auto-increment the word index
// after every 32-bit data word instead of ending the frame.
// Ports:
//   CLK, reset            system clock, synchronous active-high reset
//   spi_clk/cs_n/mosi     SPI inputs from the master
//   spi_miso              SPI data to the master (0 outside the read data phase)
//   busy                  synchronised cs_n is low
//   wr_pulse              one-CLK pulse per committed write word
//   cmd_err               sticky unknown-command flag
//   dbg_idx / dbg_rd      combinational backdoor read of the memory
module spi_mem_responder #(
  parameter int unsigned MEM_WORDS = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             spi_clk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             busy,
  output logic             wr_pulse,
  output logic             cmd_err,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [31:0]      dbg_rd
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StTx, StRx, StDone, StIgnore} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic             sclk_prev_q, cs_prev_q;
  logic [5:0]       cnt_q, cnt_d;
  logic [30:0]      sr_q, sr_d;
  logic [31:0]      tx_q, tx_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rd_q, rd_d;
  logic             miso_q, miso_d;
  logic             wr_q;
  logic             err_q, err_set;
  logic             mem_we;
  logic [31:0]      mem_q [MEM_WORDS];

  logic        sclk_s, cs_s, mosi_s, rise, fall;
  logic [31:0] sr_next;
`ifdef SPI_RESP_AUTOINC_EN
  logic [IDX_W-1:0] idx_inc;
  logic [31:0]      next_word;
  assign idx_inc   = idx_q + 1'b1;
  assign next_word = mem_q[idx_inc];
`endif

  assign sclk_s  = sclk_sync_q[1];
  assign cs_s    = cs_sync_q[1];
  assign mosi_s  = mosi_sync_q[1];
  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;
  assign sr_next = {sr_q, mosi_s};

  assign spi_miso = miso_q;
  assign busy     = ~cs_s;
  assign wr_pulse = wr_q;
  assign cmd_err  = err_q;
  assign dbg_rd   = mem_q[dbg_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tx_d    = tx_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    miso_d  = 1'b0;
    err_set = 1'b0;
    mem_we  = 1'b0;
    if (cs_s) begin
      // Abort wins over any simultaneous spi_clk edge.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_prev_q) begin
            state_d = StCmd;
            cnt_d   = '0;
            sr_d    = '0;
          end
        end
        StCmd: begin
          if (rise) begin
            sr_d  = sr_next[30:0];
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd7) begin
              cnt_d = '0;
              case (sr_next[7:0])
                8'h03: begin state_d = StAddr; rd_d = 1'b1; end
                8'h02: begin state_d = StAddr; rd_d = 1'b0; end
                default: begin state_d = StIgnore; err_set = 1'b1; end
              endcase
            end
          end
        end
        StAddr: begin
          if (rise) begin
            sr_d  = sr_next[30:0];
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd23) begin
              cnt_d = '0;
              sr_d  = '0;
              idx_d = sr_next[IDX_W+1:2];
              if (rd_q) begin
                tx_d    = mem_q[sr_next[IDX_W+1:2]];
                state_d = StTx;
              end else begin
                state_d = StRx;
              end
            end
          end
        end
        StTx: begin
          miso_d = miso_q;
          if (fall && cnt_q != 6'd32) begin
            miso_d = tx_q[31];
            tx_d   = {tx_q[30:0], 1'b0};
            cnt_d  = cnt_q + 6'd1;
          end
`ifdef SPI_RESP_AUTOINC_EN
          else if (fall) begin
            // Reload on the edge that would start bit 33: no gap bit between words.
            idx_d  = idx_inc;
            miso_d = next_word[31];
            tx_d   = {next_word[30:0], 1'b0};
            cnt_d  = 6'd1;
          end
`else
          // Hold the last bit until the master samples it on the next rising edge.
          else if (rise && cnt_q == 6'd32) begin
            state_d = StDone;
            miso_d  = 1'b0;
          end
`endif
        end
        StRx: begin
          if (rise) begin
            sr_d  = sr_next[30:0];
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              mem_we = 1'b1;
              cnt_d  = '0;
`ifdef SPI_RESP_AUTOINC_EN
              idx_d  = idx_inc;
`else
              state_d = StDone;
`endif
            end
          end
        end
        StDone, StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= StIdle;
      sclk_sync_q <= '0;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      cnt_q       <= '0;
      sr_q        <= '0;
      tx_q        <= '0;
      idx_q       <= '0;
      rd_q        <= 1'b0;
      miso_q      <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[0], spi_clk};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      tx_q        <= tx_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      miso_q      <= miso_d;
      wr_q        <= mem_we;
      err_q       <= err_q | err_set;
      if (mem_we) mem_q[idx_q] <= sr_next;
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
module tb_spi_mem_responder;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, busy, wr_pulse, cmd_err;
  logic [3:0]  dbg_idx = 4'd0;
  logic [31:0] dbg_rd;

  int pass_cnt = 0;
  int chk_cnt = 0;
  int wr_seen = 0;

  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  string       name_q[$];
  int          exp_wr[$];

  spi_mem_responder #(.MEM_WORDS(16), .IDX_W(4)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .spi_clk  (spi_clk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .busy     (busy),
    .wr_pulse (wr_pulse),
    .cmd_err  (cmd_err),
    .dbg_idx  (dbg_idx),
    .dbg_rd   (dbg_rd)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  // Monitor: read words and write pulses are checked against the queues.
  initial begin
    forever begin
      @(negedge CLK);
      if (wr_pulse) begin
        wr_seen++;
        chk("wr_pulse_expected", 64'(exp_wr.size() > 0), 64'd1);
        if (exp_wr.size() > 0) void'(exp_wr.pop_front());
      end
      if (obs_q.size() > 0 && exp_q.size() > 0)
        chk(name_q.pop_front(), obs_q.pop_front(), exp_q.pop_front());
    end
  end

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (5) @(negedge CLK);
    m = spi_miso;
    spi_clk = 1'b1;
    repeat (5) @(negedge CLK);
    spi_clk = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge CLK);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge CLK);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input logic [63:0] wd,
                      input int nd, output logic [63:0] rd, output logic any);
    logic [31:0] hdr;
    logic m;
    hdr = {cmd, addr};
    rd = '0;
    any = 1'b0;
    cs_low();
    chk("busy_in_frame", 64'(busy), 64'd1);
    for (int i = 31; i >= 0; i--) begin
      spi_bit(hdr[i], m);
      any |= m;
    end
    for (int i = 0; i < nd; i++) begin
      spi_bit(wd[nd-1-i], m);
      rd = {rd[62:0], m};
      any |= m;
    end
    cs_high();
  endtask

  task automatic read_exp(input string nm, input logic [23:0] addr, input int nd,
                          input logic [63:0] expv);
    logic [63:0] rd;
    logic any;
    exp_q.push_back(expv);
    name_q.push_back(nm);
    xfer(8'h03, addr, 64'd0, nd, rd, any);
    obs_q.push_back(rd);
    repeat (2) @(negedge CLK);
    chk({nm, "_miso_idle"}, 64'(spi_miso), 64'd0);
  endtask

  task automatic write_word(input logic [23:0] addr, input logic [31:0] d);
    logic [63:0] rd;
    logic any;
    exp_wr.push_back(1);
    xfer(8'h02, addr, {32'd0, d}, 32, rd, any);
  endtask

  task automatic peek(input string nm, input logic [3:0] idx, input logic [31:0] expv);
    dbg_idx = idx;
    #1;
    chk(nm, {32'd0, dbg_rd}, {32'd0, expv});
  endtask

  initial begin
    logic [63:0] rd;
    logic any, m;
    int w0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    chk("rst_miso", 64'(spi_miso), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr", 64'(wr_pulse), 64'd0);
    chk("rst_err", 64'(cmd_err), 64'd0);
    peek("rst_mem2", 4'd2, 32'd0);

    // Write then read.
    w0 = wr_seen;
    write_word(24'h000008, 32'hDEADBEEF);
    chk("wr_count_1", 64'(wr_seen - w0), 64'd1);
    peek("wr_idx2", 4'd2, 32'hDEADBEEF);
    read_exp("rd_idx2", 24'h000008, 32, 64'h00000000DEADBEEF);
`ifndef SPI_RESP_AUTOINC_EN
    // Bits past the single data word must read 0.
    read_exp("rd_overrun", 24'h000008, 40, 64'h000000DEADBEEF00);
`endif

    // Aliasing: address 0x40 wraps to index 0.
    write_word(24'h000040, 32'h12345678);
    peek("alias_idx0", 4'd0, 32'h12345678);

    // Unknown command.
    w0 = wr_seen;
    xfer(8'hA5, 24'h000008, 64'h00000000CAFEF00D, 32, rd, any);
    chk("bad_err", 64'(cmd_err), 64'd1);
    chk("bad_miso", 64'(any), 64'd0);
    chk("bad_no_wr", 64'(wr_seen - w0), 64'd0);
    peek("bad_mem", 4'd2, 32'hDEADBEEF);
    read_exp("bad_then_rd", 24'h000008, 32, 64'h00000000DEADBEEF);
    chk("err_sticky", 64'(cmd_err), 64'd1);

    // Abort after 20 data bits.
    w0 = wr_seen;
    cs_low();
    for (int i = 31; i >= 0; i--) begin
      logic [31:0] h;
      h = 32'h02000008;
      spi_bit(h[i], m);
    end
    for (int i = 0; i < 20; i++) spi_bit(i[0], m);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge CLK);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (6) @(negedge CLK);
    chk("abort_no_wr", 64'(wr_seen - w0), 64'd0);
    peek("abort_mem", 4'd2, 32'hDEADBEEF);
    read_exp("abort_then_rd", 24'h000008, 32, 64'h00000000DEADBEEF);

    // Reset in the middle of a read data phase.
    cs_low();
    for (int i = 31; i >= 0; i--) begin
      logic [31:0] h;
      h = 32'h03000008;
      spi_bit(h[i], m);
    end
    for (int i = 0; i < 6; i++) spi_bit(1'b0, m);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rstmid_miso", 64'(spi_miso), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    spi_cs_n = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rstmid_err", 64'(cmd_err), 64'd0);
    for (int i = 0; i < 16; i++) peek("rstmid_mem", 4'(i), 32'd0);
    write_word(24'h00000C, 32'hAABBCCDD);
    peek("post_rst_wr", 4'd3, 32'hAABBCCDD);
    read_exp("post_rst_rd", 24'h00000C, 32, 64'h00000000AABBCCDD);

`ifdef SPI_RESP_AUTOINC_EN
    w0 = wr_seen;
    exp_wr.push_back(1);
    exp_wr.push_back(1);
    xfer(8'h02, 24'h00003C, 64'h1111111122222222, 64, rd, any);
    chk("burst_wr_count", 64'(wr_seen - w0), 64'd2);
    peek("burst_idx15", 4'd15, 32'h11111111);
    peek("burst_idx0", 4'd0, 32'h22222222);
    read_exp("burst_rd", 24'h00003C, 64, 64'h1111111122222222);
`endif

    repeat (10) @(negedge CLK);
    chk("obs_drained", 64'(obs_q.size()), 64'd0);
    chk("wr_drained", 64'(exp_wr.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
